// File: rtl/muldiv_sched.sv
// Execution-side controller for the M-extension unit: launches ops into the pipelined
// multiplier or iterative divider, tracks in-flight tags and arbitrates one writeback port.
module muldiv_sched #(
   parameter int XLEN    = 64,
   parameter int RB      = 2,
   parameter int MUL_LAT = 3
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            flush,
   input  logic            exe_vaild,
   input  logic [12:0]     exe_op,
   input  logic [4+RB:0]   exe_rd0,
   input  logic [XLEN-1:0] exe_op1,
   input  logic [XLEN-1:0] exe_op2,
   output logic            execute_ready,
   output logic            mul_start,
   output logic [12:0]     md_op,
   output logic [XLEN-1:0] md_op1,
   output logic [XLEN-1:0] md_op2,
   input  logic [XLEN-1:0] mul_res,
   output logic            div_start,
   output logic            div_kill,
   input  logic            div_done,
   input  logic [XLEN-1:0] div_res,
   output logic            wb_vaild,
   output logic [4+RB:0]   wb_rd0,
   output logic [XLEN-1:0] wb_res
);

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} div_state_t;

   div_state_t          state, state_n;
   logic                is_mul, is_div, is_w, accept;
   logic [MUL_LAT-1:0]  pipe_v, pipe_w;
   logic [4+RB:0]       pipe_rd [MUL_LAT];
   logic                mul_exit;
   logic [4+RB:0]       div_rd;
   logic                div_w;
   logic [XLEN-1:0]     hold_res;
   logic                hold_load;
   logic                wb_v_n;
   logic [4+RB:0]       wb_rd_n;
   logic [XLEN-1:0]     wb_res_n;

   function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] r, input logic w);
      return w ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
   endfunction

   // exe_op bit order: mul mulh mulhsu mulhu div divu rem remu mulw divw divuw remw remuw
   assign is_mul = |{exe_op[12:9], exe_op[4]};
   assign is_div = |{exe_op[8:5], exe_op[3:0]};
   assign is_w   = |exe_op[4:0];
   assign accept = exe_vaild & ~flush & ~RST;

   assign mul_start     = accept & is_mul;
   assign div_start     = accept & is_div;
   assign div_kill      = (state == BUSY) & flush & ~RST;
   assign execute_ready = (state == IDLE) & ~flush & ~RST;
   assign md_op         = RST ? '0 : exe_op;
   assign md_op1        = RST ? '0 : exe_op1;
   assign md_op2        = RST ? '0 : exe_op2;
   assign mul_exit      = pipe_v[MUL_LAT-1];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pipe_v <= '0;
      end else if (flush) begin
         pipe_v <= '0;
      end else begin
         pipe_v[0] <= mul_start;
         for (int i = 1; i < MUL_LAT; i++) pipe_v[i] <= pipe_v[i-1];
      end
   end

   // NOTE: payload registers carry no reset; they are only consumed under a valid bit or FSM state that is reset.
   always_ff @(posedge CLK) begin
      pipe_rd[0] <= exe_rd0;
      pipe_w[0]  <= is_w;
      for (int i = 1; i < MUL_LAT; i++) begin
         pipe_rd[i] <= pipe_rd[i-1];
         pipe_w[i]  <= pipe_w[i-1];
      end
      if (div_start) begin
         div_rd <= exe_rd0;
         div_w  <= is_w;
      end
      if (hold_load) hold_res <= div_res;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_n   = state;
      hold_load = 1'b0;
      wb_v_n    = 1'b0;
      wb_rd_n   = wb_rd0;
      wb_res_n  = wb_res;
      unique case (state)
         IDLE: if (div_start) state_n = BUSY;
         BUSY: begin
            if (div_done) begin
               if (mul_exit) begin
                  state_n   = HOLD;
                  hold_load = 1'b1;
               end else begin
                  state_n  = IDLE;
                  wb_v_n   = 1'b1;
                  wb_rd_n  = div_rd;
                  wb_res_n = wext(div_res, div_w);
               end
            end
         end
         HOLD: begin
            if (!mul_exit) begin
               state_n  = IDLE;
               wb_v_n   = 1'b1;
               wb_rd_n  = div_rd;
               wb_res_n = wext(hold_res, div_w);
            end
         end
         default: state_n = IDLE;
      endcase
      // The multiplier cannot stall, so its exiting result always owns the port.
      if (mul_exit) begin
         wb_v_n   = 1'b1;
         wb_rd_n  = pipe_rd[MUL_LAT-1];
         wb_res_n = wext(mul_res, pipe_w[MUL_LAT-1]);
      end
      if (flush) begin
         state_n   = IDLE;
         hold_load = 1'b0;
         wb_v_n    = 1'b0;
         wb_rd_n   = wb_rd0;
         wb_res_n  = wb_res;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         wb_vaild <= 1'b0;
         wb_rd0   <= '0;
         wb_res   <= '0;
      end else begin
         state    <= state_n;
         wb_vaild <= wb_v_n;
         wb_rd0   <= wb_rd_n;
         wb_res   <= wb_res_n;
      end
   end

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: the bench plays multiplier and divider, queues
// expected writebacks at issue time and a negedge monitor pops and compares them.
module tb_muldiv_sched;

   localparam int XLEN    = 64;
   localparam int RB      = 2;
   localparam int MUL_LAT = 3;

   logic            CLK = 1'b0;
   logic            RST;
   logic            flush;
   logic            exe_vaild;
   logic [12:0]     exe_op;
   logic [4+RB:0]   exe_rd0;
   logic [XLEN-1:0] exe_op1, exe_op2;
   logic            execute_ready, mul_start, div_start, div_kill;
   logic [12:0]     md_op;
   logic [XLEN-1:0] md_op1, md_op2;
   logic [XLEN-1:0] mul_res, div_res;
   logic            div_done;
   logic            wb_vaild;
   logic [4+RB:0]   wb_rd0;
   logic [XLEN-1:0] wb_res;

   muldiv_sched #(.XLEN(XLEN), .RB(RB), .MUL_LAT(MUL_LAT)) dut (
      .CLK(CLK), .RST(RST), .flush(flush), .exe_vaild(exe_vaild), .exe_op(exe_op),
      .exe_rd0(exe_rd0), .exe_op1(exe_op1), .exe_op2(exe_op2),
      .execute_ready(execute_ready), .mul_start(mul_start),
      .md_op(md_op), .md_op1(md_op1), .md_op2(md_op2), .mul_res(mul_res),
      .div_start(div_start), .div_kill(div_kill), .div_done(div_done), .div_res(div_res),
      .wb_vaild(wb_vaild), .wb_rd0(wb_rd0), .wb_res(wb_res)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [6:0]  rd;
      logic [63:0] res;
      bit          is_div;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] mres  [int];
   logic [63:0] ddone [int];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          wb_seen = 0;
   bit          div_pending = 0;
   int          div_issue_cyc = 0;
   int          div_done_cyc = 0;
   exp_t        mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] sext32(input logic [63:0] v);
      int lo;
      lo = int'(v[31:0]);
      return 64'(longint'(lo));
   endfunction

   always @(posedge CLK) cyc <= cyc + 1;

   // Multiplier and divider models: results land on the cycle scheduled at issue.
   always @(posedge CLK) begin
      #1;
      if (mres.exists(cyc)) begin
         mul_res = mres[cyc];
         mres.delete(cyc);
      end else begin
         mul_res = {$urandom, $urandom};
      end
      if (ddone.exists(cyc)) begin
         div_done = 1'b1;
         div_res  = ddone[cyc];
         ddone.delete(cyc);
      end else begin
         div_done = 1'b0;
         div_res  = {$urandom, $urandom};
      end
   end

   always @(negedge CLK) begin
      if (!RST && wb_vaild) begin
         wb_seen++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_wb: got rd %h res %h, required no writeback (cycle %0d)",
                     wb_rd0, wb_res, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("wb_rd0", 64'(wb_rd0), 64'(mon_e.rd));
            check("wb_res", wb_res, mon_e.res);
            if (mon_e.is_div) div_pending = 0;
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      exe_vaild = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic clear_model();
      exp_q.delete();
      ddone.delete();
      div_pending = 0;
   endtask

   // idx follows exe_op bit numbering (12 = mul ... 0 = remuw).
   task automatic issue(input int idx, input logic [6:0] rd, input logic [63:0] a,
                        input logic [63:0] b, input int dlat);
      bit          acc, mc, w;
      logic [63:0] r;
      exp_t        e;
      exe_vaild = 1'b1;
      exe_op    = 13'b1 << idx;
      exe_rd0   = rd;
      exe_op1   = a;
      exe_op2   = b;
      #1;
      acc = !flush;
      mc  = (idx >= 9) || (idx == 4);
      w   = (idx <= 4);
      check("mul_start", 64'(mul_start), 64'(acc && mc));
      check("div_start", 64'(div_start), 64'(acc && !mc));
      if (acc) begin
         if (mc) begin
            r = a * b;
            mres[cyc + MUL_LAT] = r;
         end else begin
            r = {$urandom, $urandom};
            ddone[cyc + dlat] = r;
            div_pending   = 1;
            div_issue_cyc = cyc;
            div_done_cyc  = cyc + dlat;
         end
         e.rd     = rd;
         e.res    = w ? sext32(r) : r;
         e.is_div = !mc;
         exp_q.push_back(e);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, 64'(execute_ready), 64'd0);
      check({tag, "_mul_start"}, 64'(mul_start), 64'd0);
      check({tag, "_div_start"}, 64'(div_start), 64'd0);
      check({tag, "_div_kill"}, 64'(div_kill), 64'd0);
      check({tag, "_wb_vaild"}, 64'(wb_vaild), 64'd0);
      check({tag, "_wb_rd0"}, 64'(wb_rd0), 64'd0);
      check({tag, "_wb_res"}, wb_res, 64'd0);
   endtask

   initial begin
      int seen;
      int n;
      int r;
      RST       = 1'b1;
      flush     = 1'b0;
      exe_vaild = 1'b1;
      exe_op    = 13'h1000;
      exe_rd0   = '0;
      exe_op1   = '0;
      exe_op2   = '0;
      div_done  = 1'b0;
      mul_res   = '0;
      div_res   = '0;
      #12;
      check_all_zero("reset");
      @(posedge CLK);
      #1;
      RST       = 1'b0;
      exe_vaild = 1'b0;

      // Single mul: result 15 four cycles after accept.
      tick();
      issue(12, 7'h15, 64'd3, 64'd5, 0);
      check("md_op1", md_op1, 64'd3);
      for (int i = 1; i <= 4; i++) begin
         tick();
         #1;
         check("t1_wb_vaild", 64'(wb_vaild), 64'(i == 4));
      end
      check("t1_wb_rd0", 64'(wb_rd0), 64'h15);
      check("t1_wb_res", wb_res, 64'd15);

      // Four back-to-back mulw with bit 31 set: sign-extended, no stall.
      for (int i = 0; i < 4; i++) begin
         tick();
         issue(4, 7'(8'h40 + i), 64'h8000_0000, 64'd1, 0);
         check("t2_ready_issue", 64'(execute_ready), 64'd1);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         check("t2_wb_vaild", 64'(wb_vaild), 64'd1);
         check("t2_wb_res", wb_res, 64'hFFFF_FFFF_8000_0000);
         check("t2_ready", 64'(execute_ready), 64'd1);
      end

      // mul at t, div at t+1 finishing at t+3 together with the mul exit.
      tick();
      issue(12, 7'h21, 64'd7, 64'd6, 0);
      tick();
      issue(8, 7'h22, 64'd100, 64'd7, 2);
      for (int i = 2; i <= 5; i++) begin
         tick();
         #1;
         check("t3_ready", 64'(execute_ready), 64'(i == 5));
         if (i == 4) check("t3_wb_mul_rd", 64'(wb_rd0), 64'h21);
         if (i == 5) check("t3_wb_div_rd", 64'(wb_rd0), 64'h22);
         if (i >= 4) check("t3_wb_vaild", 64'(wb_vaild), 64'd1);
      end

      // Divide killed by flush two cycles after accept; late div_done ignored.
      tick();
      issue(6, 7'h30, 64'd50, 64'd3, 30);
      tick();
      tick();
      flush = 1'b1;
      #1;
      check("t4_div_kill", 64'(div_kill), 64'd1);
      check("t4_ready_flush", 64'(execute_ready), 64'd0);
      tick();
      clear_model();
      #1;
      check("t4_ready_after", 64'(execute_ready), 64'd1);
      check("t4_no_kill_after", 64'(div_kill), 64'd0);
      ddone[cyc + 1] = 64'hDEAD_BEEF;
      seen = wb_seen;
      repeat (5) tick();
      check("t4_no_wb_late_done", 64'(wb_seen), 64'(seen));

      // Three muls in flight flushed; a mul right after the flush writes back.
      for (int i = 0; i < 3; i++) begin
         tick();
         issue(12, 7'(8'h50 + i), 64'(i + 2), 64'd3, 0);
      end
      tick();
      flush = 1'b1;
      tick();
      clear_model();
      seen = wb_seen;
      issue(12, 7'h3F, 64'd9, 64'd9, 0);
      repeat (4) tick();
      check("t5_no_wb_after_flush", 64'(wb_seen), 64'(seen));
      #1;
      check("t5_wb_vaild", 64'(wb_vaild), 64'd1);
      check("t5_wb_rd0", 64'(wb_rd0), 64'h3F);
      check("t5_wb_res", wb_res, 64'd81);

      // Reset while the divider is busy.
      tick();
      issue(7, 7'h11, 64'd1000, 64'd10, 20);
      tick();
      tick();
      exe_vaild = 1'b1;
      exe_op    = 13'h1000;
      RST       = 1'b1;
      #1;
      check_all_zero("t6_rst");
      clear_model();
      tick();
      tick();
      RST = 1'b0;
      #1;
      check("t6_ready_release", 64'(execute_ready), 64'd1);
      ddone[cyc + 1] = 64'h1234;
      seen = wb_seen;
      repeat (4) tick();
      check("t6_no_wb_stray_done", 64'(wb_seen), 64'(seen));

      // Randomised traffic with occasional flushes.
      for (int k = 0; k < 500; k++) begin
         tick();
         #1;
         if (!div_pending) check("rnd_ready", 64'(execute_ready), 64'd1);
         r = $urandom_range(0, 99);
         if (r < 4) begin
            flush = 1'b1;
            #1;
            if (!div_pending)
               check("rnd_kill_idle", 64'(div_kill), 64'd0);
            else if (cyc > div_issue_cyc && cyc <= div_done_cyc)
               check("rnd_kill_busy", 64'(div_kill), 64'd1);
            if (r < 2 && !div_pending)
               issue($urandom_range(0, 12), 7'($urandom), 64'd5, 64'd5, MUL_LAT);
            tick();
            clear_model();
         end else if (!div_pending && r < 75) begin
            issue($urandom_range(0, 12), 7'($urandom), {$urandom, $urandom},
                  {$urandom, $urandom}, $urandom_range(MUL_LAT - 1, MUL_LAT + 6));
         end
      end

      n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         tick();
         n++;
      end
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Execution-side controller for the M-extension unit; sits between the mul issue register and the shared multiplier/divider datapaths.
- Launches each issued op into either the fixed-latency pipelined multiplier or the iterative divider, and tracks the in-flight destination tags.
- Arbitrates the single writeback port and applies W-variant sign extension.
- Generates the `execute_ready` back-pressure that the mul issue stage consumes.

Parameters:
- XLEN, 64, operand/result width
- RB, 2, rename-bit width appended to the 5-bit architectural register index
- MUL_LAT, 3, multiplier latency in cycles, start to result; must be ≥1

Ports:
- CLK  in  1  clock
- RST  in  1  reset; one clock, asynchronous, active-high
- flush  in  1  pipeline flush
- exe_vaild  in  1  issued-op valid pulse, one op per cycle
- exe_op  in  13  one-hot op, MSB→LSB: mul, mulh, mulhsu, mulhu, div, divu, rem, remu, mulw, divw, divuw, remw, remuw
- exe_rd0  in  5+RB  destination tag
- exe_op1, exe_op2  in  XLEN  source operands
- execute_ready  out  1  controller can accept an op next cycle
- mul_start  out  1  multiplier launch; operands and op pass straight through
- mul_res  in  XLEN  multiplier result, valid exactly MUL_LAT cycles after `mul_start`
- div_start  out  1  divider launch pulse
- div_kill  out  1  divider abort pulse
- div_done  in  1  divider result-valid pulse
- div_res  in  XLEN  divider result
- wb_vaild  out  1  writeback valid (registered)
- wb_rd0  out  5+RB  writeback tag (registered)
- wb_res  out  XLEN  writeback data (registered)

Behaviour:
- Reset: all outputs 0; mul pipe valid bits 0; divider FSM IDLE; hold register empty.
- Op classes:
  - mul-class = mul, mulh, mulhsu, mulhu, mulw.
  - div-class = remaining 8 ops.
  - W-flag = mulw, divw, divuw, remw, remuw.
- Launch (combinational, same cycle as accept):
  - Accept when `exe_vaild & ~flush`.
  - Mul-class: `mul_start`=1.
  - Div-class: `div_start`=1, FSM IDLE→BUSY.
  - An `exe_vaild` arriving while `execute_ready` was 0 in the prior cycle is a protocol error; it is not required to be handled.
- Mul tracking: MUL_LAT-deep shift register of {valid, rd0, W}; entry enters on `mul_start`; the exiting entry pairs with `mul_res`.
- Divider FSM:
  - IDLE: `div_start` → BUSY.
  - BUSY, `div_done`, no mul exit this cycle → result to wb register; next state IDLE.
  - BUSY, `div_done` coinciding with a valid mul exit → mul wins; div result and tag latched in hold; next state HOLD.
  - HOLD: emit held result in the first cycle with no valid mul exit → IDLE.
  - `div_done` in IDLE or HOLD is ignored.
  - The divide tag and W-flag are captured at `div_start`.
- Ready: `execute_ready` = (FSM==IDLE) & ~flush.
  - Muls stream back-to-back while no divide is outstanding.
  - A divide blocks all further issue until its writeback; the mul pipe drains meanwhile, so HOLD always exits within MUL_LAT cycles.
- Writeback:
  - Registered; wb outputs update one cycle after the result event.
  - W-flag set: `wb_res` = sign-extend of result[31:0]; otherwise the full result.
  - `wb_vaild` is 1 for exactly one cycle per op.
  - If no result is available, `wb_vaild`=0 and `wb_rd0`/`wb_res` hold their last values.
- Flush:
  - Same cycle: clears all mul valid bits and the hold register; forces FSM to IDLE.
  - Asserts `div_kill` if FSM is BUSY.
  - Suppresses accept; next-cycle `wb_vaild`=0.
  - Results landing in the flush cycle are dropped.
  - `div_done` in the cycle after flush is ignored, since the FSM is IDLE.
- Reset mid-operation behaves as flush plus register clear; `div_kill` is not required during reset.

Test Plan:
- Reset, then mul op rd0=0x15, op1=3, op2=5, MUL_LAT=3, accept at t → `mul_start` at t; `wb_vaild` at t+4 with `wb_rd0`=0x15, `wb_res`=15.
- 4 back-to-back mulw ops, result 0x0000_0000_8000_0000 → 4 consecutive `wb_vaild` cycles, each `wb_res`=0xFFFF_FFFF_8000_0000; `execute_ready` stays 1 throughout.
- mul at t, div at t+1, `div_done` forced at t+3 (coincides with mul exit) → wb mul at t+4, wb div at t+5; `execute_ready`=0 from t+2 through t+4, back to 1 at t+5.
- div accepted, flush 2 cycles later → `div_kill` pulse in the flush cycle; `execute_ready`=1 the next cycle; a late `div_done` produces no `wb_vaild`.
- 3 muls in flight, flush → no `wb_vaild` for the next MUL_LAT+1 cycles; a new mul accepted right after the flush writes back normally.
- RST asserted while FSM BUSY → all outputs 0 immediately; after release `execute_ready`=1 and a stray `div_done` is ignored.
